// File: rtl/tweak_pkg.sv
// Shared definitions for the tweak CPU front end.
// Holds the fetch FSM state type, default address/data widths and the
// instruction word width shared by the fetch stage, decoder and ROM.
package tweak_pkg;

    localparam int unsigned TWEAK_ADDR_W = 4;
    localparam int unsigned TWEAK_DATA_W = 32;
    localparam int unsigned TWEAK_INSN_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalted
    } fetch_state_e;

endpackage

// File: rtl/tweak_fetch_fifo.sv
// Synchronous instruction buffer for the fetch stage, with flush.
// Ports:
//   CLK, NRES    clock, asynchronous active-low reset
//   push/push_data  write an entry at the tail
//   pop          remove the head entry (caller guarantees valid)
//   flush        empty the buffer; overrides push and pop
//   count        current occupancy
//   valid/head   head entry present / head entry contents
// Push and pop in the same cycle is legal at any occupancy, including full:
// the popped head slot is the one being overwritten.
module tweak_fetch_fifo
    import tweak_pkg::*;
#(
    parameter int unsigned WIDTH = TWEAK_INSN_W + TWEAK_ADDR_W,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             NRES,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign valid = (count != '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/tweak_fetch.sv
// Instruction fetch stage of the tweak CPU.
// Owns the PC, issues single-cycle-latency ROM reads, buffers returned words
// with their PC and hands them to the decoder over valid/ready.
// Ports:
//   CLK, NRES                 clock, asynchronous active-low reset
//   rom_rd/rom_addr/rom_data  ROM read strobe, address, data (next cycle)
//   ins_valid/ins_ready       handshake to the decoder
//   ins_data/ins_pc           head instruction word and its PC
//   redir_valid/redir_pc      redirect: flush buffer, kill inflight, load PC
//   halt                      level; suppresses new reads while high
//   fetch_count               pop counter, only with TWEAK_FETCH_PERF_EN
// Build option: define TWEAK_FETCH_PERF_EN to add the fetch_count port.
module tweak_fetch
    import tweak_pkg::*;
#(
    parameter int unsigned ADDR_W     = TWEAK_ADDR_W,
    parameter int unsigned DATA_W     = TWEAK_DATA_W,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              NRES,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [DATA_W-1:0] ins_data,
    output logic [ADDR_W-1:0] ins_pc,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc,
    input  logic              halt
`ifdef TWEAK_FETCH_PERF_EN
    ,
    output logic [15:0]       fetch_count
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENT_W = DATA_W + ADDR_W;

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;

    logic              redir;
    logic              push;
    logic              pop;
    logic              fifo_valid;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENT_W-1:0]  fifo_head;
    logic [CNT_W:0]    occupancy;

    // Redirect is ignored in IDLE; nothing is buffered or inflight there.
    assign redir = redir_valid && (state != StIdle);

    // A redirect hides the head so a concurrent ready cannot pop stale data.
    assign ins_valid = fifo_valid && !redir;
    assign pop       = ins_valid && ins_ready;
    assign push      = inflight && !redir;

    // Slots already committed (buffered + inflight) after this cycle's pop.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight}
                     - {{CNT_W{1'b0}}, pop};

    assign rom_rd   = (state == StRun) && !halt && !redir_valid
                   && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign rom_addr = pc;

    assign ins_data = fifo_head[ENT_W-1:ADDR_W];
    assign ins_pc   = fifo_head[ADDR_W-1:0];

    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            state       <= StIdle;
            pc          <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            case (state)
                StIdle:   state <= StRun;
                StRun:    if (halt) state <= StHalted;
                StHalted: if (!halt) state <= StRun;
                default:  state <= StIdle;
            endcase

            if (redir) begin
                pc <= redir_pc;
            end else if (rom_rd) begin
                pc <= pc + ADDR_W'(1);
            end

            // rom_rd is low during a redirect, so this also kills the response.
            inflight <= rom_rd;
            if (rom_rd) begin
                inflight_pc <= pc;
            end
        end
    end

    tweak_fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .NRES      (NRES),
        .push      (push),
        .push_data ({rom_data, inflight_pc}),
        .pop       (pop),
        .flush     (redir),
        .count     (fifo_count),
        .valid     (fifo_valid),
        .head      (fifo_head)
    );

`ifdef TWEAK_FETCH_PERF_EN
    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            fetch_count <= '0;
        end else if (pop) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tweak_fetch.sv
// Self-checking bench for tweak_fetch: per-cycle vector table plus a
// mid-stream asynchronous reset sequence.
module tb_tweak_fetch;

    logic        CLK = 1'b0;
    logic        NRES = 1'b0;
    logic        rom_rd;
    logic [3:0]  rom_addr;
    logic [31:0] rom_data = '0;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic [31:0] ins_data;
    logic [3:0]  ins_pc;
    logic        redir_valid = 1'b0;
    logic [3:0]  redir_pc = '0;
    logic        halt = 1'b0;
`ifdef TWEAK_FETCH_PERF_EN
    logic [15:0] fetch_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_pops = 0;

    always #5 CLK = ~CLK;

    // ROM model: word k = 32'h1000_0000 + k, one cycle read latency.
    always @(posedge CLK) begin
        if (rom_rd) rom_data <= 32'h1000_0000 + {28'd0, rom_addr};
    end

    tweak_fetch dut (
        .CLK         (CLK),
        .NRES        (NRES),
        .rom_rd      (rom_rd),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_data    (ins_data),
        .ins_pc      (ins_pc),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .halt        (halt)
`ifdef TWEAK_FETCH_PERF_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    typedef struct {
        logic       ready;
        logic       hlt;
        logic       rv;
        logic [3:0] rpc;
        logic       e_rd;
        logic [3:0] e_addr;
        logic       e_valid;
        logic [3:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic ready, input logic hlt, input logic rv,
                                input logic [3:0] rpc, input logic e_rd,
                                input logic [3:0] e_addr, input logic e_valid,
                                input logic [3:0] e_pc);
        vec_t v;
        v.ready = ready; v.hlt = hlt; v.rv = rv; v.rpc = rpc;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " rom_rd"}, {31'd0, rom_rd}, 32'd0);
        check({tag, " rom_addr"}, {28'd0, rom_addr}, 32'd0);
        check({tag, " ins_valid"}, {31'd0, ins_valid}, 32'd0);
        check({tag, " ins_data"}, ins_data, 32'd0);
        check({tag, " ins_pc"}, {28'd0, ins_pc}, 32'd0);
`ifdef TWEAK_FETCH_PERF_EN
        check({tag, " fetch_count"}, {16'd0, fetch_count}, 32'd0);
`endif
    endtask

    // Applies vecs[first..last]; entry i drives and checks cycle (i - first + 1).
    task automatic run_vectors(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            string tag;
            @(negedge CLK);
            ins_ready   = vecs[i].ready;
            halt        = vecs[i].hlt;
            redir_valid = vecs[i].rv;
            redir_pc    = vecs[i].rpc;
            #1;
            tag = $sformatf("cyc%0d", i - first + 1);
`ifdef TWEAK_FETCH_PERF_EN
            check({tag, " fetch_count"}, {16'd0, fetch_count}, exp_pops);
`endif
            check({tag, " rom_rd"}, {31'd0, rom_rd}, {31'd0, vecs[i].e_rd});
            if (vecs[i].e_rd)
                check({tag, " rom_addr"}, {28'd0, rom_addr}, {28'd0, vecs[i].e_addr});
            check({tag, " ins_valid"}, {31'd0, ins_valid}, {31'd0, vecs[i].e_valid});
            if (vecs[i].e_valid) begin
                check({tag, " ins_pc"}, {28'd0, ins_pc}, {28'd0, vecs[i].e_pc});
                check({tag, " ins_data"}, ins_data, 32'h1000_0000 + {28'd0, vecs[i].e_pc});
                if (vecs[i].ready) exp_pops++;
            end
        end
    endtask

    initial begin
        int main_last;
        int rst_last;

        // Phase 1: decoder stalled from reset, then streaming.
        add(0,0,0,0, 1,0,  0,0);   // c1  first read at addr 0
        add(0,0,0,0, 1,1,  0,0);   // c2
        add(0,0,0,0, 0,0,  1,0);   // c3  buffer+inflight full, reads stop
        for (int k = 4; k <= 10; k++) add(0,0,0,0, 0,0, 1,0);
        add(1,0,0,0, 1,2,  1,0);   // c11 ready rises
        add(1,0,0,0, 1,3,  1,1);
        add(1,0,0,0, 1,4,  1,2);
        add(1,0,0,0, 1,5,  1,3);
        add(0,0,0,0, 0,0,  1,4);   // c15 fills the buffer
        add(1,0,0,0, 1,6,  1,4);   // c16 full pop + issue
        add(1,0,1,5, 0,0,  0,0);   // c17 redirect to 5 with inflight read
        add(1,0,0,0, 1,5,  0,0);
        add(1,0,0,0, 1,6,  0,0);
        add(1,0,0,0, 1,7,  1,5);   // c20 = redirect + 3
        add(1,0,0,0, 1,8,  1,6);
        add(1,0,1,14,0,0,  0,0);   // c22 redirect to 14
        add(1,0,0,0, 1,14, 0,0);
        add(1,0,0,0, 1,15, 0,0);
        add(1,0,0,0, 1,0,  1,14);  // c25 address wraps 15 -> 0
        add(1,0,0,0, 1,1,  1,15);
        add(1,0,0,0, 1,2,  1,0);
        add(1,0,0,0, 1,3,  1,1);
        add(1,1,0,0, 0,0,  1,2);   // c29 halt for five cycles
        add(1,1,0,0, 0,0,  1,3);   //     inflight word still delivered
        add(1,1,0,0, 0,0,  0,0);
        add(1,1,0,0, 0,0,  0,0);
        add(1,1,0,0, 0,0,  0,0);
        add(1,0,0,0, 0,0,  0,0);   // c34 halt falls, FSM still HALTED
        add(1,0,0,0, 1,4,  0,0);   // c35 resumes at next sequential pc
        add(1,0,0,0, 1,5,  0,0);
        add(1,0,0,0, 1,6,  1,4);
        main_last = vecs.size() - 1;
        // Restart after mid-stream reset, decoder always ready.
        add(1,0,0,0, 1,0,  0,0);
        add(1,0,0,0, 1,1,  0,0);
        add(1,0,0,0, 1,2,  1,0);
        add(1,0,0,0, 1,3,  1,1);
        add(1,0,0,0, 1,4,  1,2);
        rst_last = vecs.size() - 1;

        repeat (3) @(negedge CLK);
        check_reset("reset");
        NRES = 1'b1;
        run_vectors(0, main_last);

        // Asynchronous reset mid-cycle: outputs clear without a clock edge.
        #2 NRES = 1'b0;
        #1 check_reset("midreset");
        exp_pops = 0;
        repeat (2) @(negedge CLK);
        NRES = 1'b1;
        run_vectors(main_last + 1, rst_last);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tweak_fetch.md
# tweak_fetch

Instruction fetch stage of the tweak CPU, directly upstream of `tweak_decoder`. Owns the program counter and issues single-cycle-latency reads to the instruction ROM. Buffers returned words with their PC in a small FIFO and hands them to the decode stage over a valid/ready handshake. Supports PC redirect, which flushes the FIFO, and a halt input that stops issuing reads.

## Interface
Parameters:
- `ADDR_W`, 4: PC/ROM address width; the PC wraps modulo 2^ADDR_W.
- `DATA_W`, 32: instruction word width.
- `FIFO_DEPTH`, 2: instruction buffer entries; power of two, ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `CLK`  in  1  sole clock; all state updates on posedge.
- `NRES`  in  1  asynchronous active-low reset.
- `rom_rd`  out  1  read strobe; ROM presents the word on `rom_data` in the following cycle.
- `rom_addr`  out  ADDR_W  read address; meaningful only while `rom_rd`=1.
- `rom_data`  in  DATA_W  ROM read data.
- `ins_valid`  out  1  FIFO head holds an instruction.
- `ins_ready`  in  1  decoder accepts the head this cycle.
- `ins_data`  out  DATA_W  head instruction word.
- `ins_pc`  out  ADDR_W  PC of the head instruction.
- `redir_valid`  in  1  redirect request.
- `redir_pc`  in  ADDR_W  redirect target.
- `halt`  in  1  level input; suppresses new reads while high.
- `fetch_count`  out  16  retired-fetch counter; present only with `TWEAK_FETCH_PERF_EN`.

## Operation
- FSM states:
  - IDLE: entered on reset; moves to RUN on the first clock.
  - RUN: moves to HALTED when `halt`=1.
  - HALTED: moves to RUN when `halt`=0.
  - `redir_valid` is honoured in RUN and HALTED.
- Issue condition: `rom_rd` = RUN & !halt & !redir_valid & (count + inflight − pop < FIFO_DEPTH).
  - `pop` = ins_valid & ins_ready.
  - `inflight` is a 1-bit flag, set on the cycle after `rom_rd`.
- `rom_addr` = PC. On issue, PC ← PC+1, wrapping from 2^ADDR_W−1 to 0 without any flag.
- Capture: when `inflight` is set and not killed, {rom_data, issued PC} is written to the FIFO tail.
- Pop: on `ins_valid & ins_ready` the head is removed.
- Simultaneous push and pop:
  - allowed at any occupancy, including full;
  - the count is unchanged;
  - a full FIFO with pop and push in the same cycle stays full with no loss.
- Redirect (highest priority):
  - the FIFO is flushed; count ← 0;
  - any inflight response is killed;
  - PC ← redir_pc;
  - no `rom_rd` is issued in the redirect cycle;
  - `ins_valid` is forced to 0 in the redirect cycle, so a concurrent `ins_ready` pops nothing.
- Halt: data already inflight is still captured; the FIFO still drains to the decoder.
- Reset mid-operation: all state clears immediately and asynchronously; no partial capture occurs.

## Timing
Reset values:
- `rom_rd`=0, `rom_addr`=0, `ins_valid`=0, `ins_data`=0, `ins_pc`=0, `fetch_count`=0.
- PC=0, FIFO empty, `inflight`=0, state IDLE.

Cycle-level behaviour:
- Cycle 0 is the first posedge after NRES rises; IDLE→RUN at that edge.
- First `rom_rd` (addr 0) is in cycle 1; `ins_valid` rises in cycle 3. Latency from `rom_rd` to `ins_valid` is 2 cycles.
- Sustained throughput is 1 instruction per cycle while `ins_ready`=1.
- Redirect latency: with `redir_valid` in cycle N, `rom_rd` at `redir_pc` occurs in cycle N+1 and `ins_valid` in cycle N+3.
- `ins_valid`, `ins_data` and `ins_pc` are registered (FIFO head); no combinational path from `ins_ready`.
- `rom_rd` is combinational from state, count, inflight, `ins_ready`, `halt` and `redir_valid`.

## Configuration
- `TWEAK_FETCH_PERF_EN` defined:
  - `fetch_count` increments by 1 on every pop and wraps at 2^16;
  - it is not cleared by redirect, only by reset.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `tweak_pkg` holds:
  - the fetch FSM state enum (IDLE/RUN/HALTED);
  - default `ADDR_W`/`DATA_W` constants;
  - the instruction word width shared with the decoder and ROM.
- One sub-module, `tweak_fetch_fifo`:
  - parameterised sync FIFO with flush;
  - storage of DATA_W+ADDR_W bits per entry;
  - push, pop, flush, count, head outputs.
- PC, inflight tracking, the FSM and the perf counter live in the top module.

## Test plan
- Reset release, ROM loaded with word k = 32'h1000_0000+k, `ins_ready`=1 → `rom_rd` in cycle 1 at addr 0; `ins_valid` in cycle 3 with data 32'h1000_0000, pc 0; one word per cycle thereafter with pc 1, 2, ….
- `ins_ready`=0 for 10 cycles → exactly FIFO_DEPTH (2) reads issued, `rom_rd` then stays 0; on raising `ins_ready`, words pc 0, 1, 2 are delivered in order with none dropped or duplicated.
- Run from pc 14 with `ins_ready`=1 → delivered pcs are 14, 15, 0, 1; `rom_addr` wraps 15→0.
- `redir_valid`=1 with `redir_pc`=5 while the FIFO is full and a read is inflight → `ins_valid`=0 next cycle, stale data never appears, next delivered pc=5, 3 cycles after redirect.
- `halt`=1 for 5 cycles mid-stream → no `rom_rd` during halt; the inflight word is still delivered; fetch resumes at the next sequential pc one cycle after `halt` falls.
- NRES pulsed low mid-stream → all outputs return to reset values immediately; after release, the sequence restarts from pc 0. With `TWEAK_FETCH_PERF_EN`, `fetch_count` equals the number of accepted handshakes and is 0 after reset.
